// File: rtl/rs_cpu_pkg.sv
// ---------------------------------------------------------------------------
// rs_cpu_pkg
// Shared definitions for the 8-bit accumulator CPU control path:
//   - 4-bit opcode constants
//   - control-unit state encoding (5 bits, so unused codes exist and are
//     recovered to FETCH1)
//   - ALU select constants, written ALUS1..ALUS7 from MSB to LSB
//   - ALU-select class used between the control unit and rs_alus_decode
//   - packed control-strobe bundle
// ---------------------------------------------------------------------------
package rs_cpu_pkg;

    // Opcodes
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDAC = 4'h1;
    localparam logic [3:0] OP_STAC = 4'h2;
    localparam logic [3:0] OP_MVAC = 4'h3;
    localparam logic [3:0] OP_MOVR = 4'h4;
    localparam logic [3:0] OP_JUMP = 4'h5;
    localparam logic [3:0] OP_JMPZ = 4'h6;
    localparam logic [3:0] OP_JPNZ = 4'h7;
    localparam logic [3:0] OP_ADD  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_INAC = 4'hA;
    localparam logic [3:0] OP_CLAC = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_NOT  = 4'hF;

    // Control-unit states. Codes 16..31 are illegal.
    typedef enum logic [4:0] {
        ST_FETCH1 = 5'd0,
        ST_FETCH2 = 5'd1,
        ST_FETCH3 = 5'd2,
        ST_DECODE = 5'd3,
        ST_OPRD   = 5'd4,
        ST_LD2    = 5'd5,
        ST_LD3    = 5'd6,
        ST_LD4    = 5'd7,
        ST_ST2    = 5'd8,
        ST_ST3    = 5'd9,
        ST_MV1    = 5'd10,
        ST_MR1    = 5'd11,
        ST_JMP1   = 5'd12,
        ST_JMP2   = 5'd13,
        ST_SKIP   = 5'd14,
        ST_ALU1   = 5'd15
    } state_t;

    // What the ALU select lines should do in the current state.
    typedef enum logic [1:0] {
        ALU_CLASS_NONE = 2'd0,  // ALUS all zero
        ALU_CLASS_PASS = 2'd1,  // AC loads the bus value unchanged
        ALU_CLASS_EXEC = 2'd2   // function chosen by the opcode
    } alu_class_t;

    // ALU select constants: bit 6 = ALUS1 ... bit 0 = ALUS7
    localparam logic [6:0] ALUS_PASS = 7'b0100000;
    localparam logic [6:0] ALUS_ADD  = 7'b1100000;
    localparam logic [6:0] ALUS_SUB  = 7'b1011000;
    localparam logic [6:0] ALUS_INAC = 7'b1001000;
    localparam logic [6:0] ALUS_CLAC = 7'b0000000;
    localparam logic [6:0] ALUS_AND  = 7'b0000001;
    localparam logic [6:0] ALUS_OR   = 7'b0000011;
    localparam logic [6:0] ALUS_XOR  = 7'b0000101;
    localparam logic [6:0] ALUS_NOT  = 7'b0000111;

    // Register load / bus enable / memory strobe bundle
    typedef struct packed {
        logic ar_load;
        logic pc_load;
        logic pc_inc;
        logic dr_load;
        logic ir_load;
        logic r_load;
        logic ac_load;
        logic pc_bus;
        logic dr_bus;
        logic r_bus;
        logic ac_bus;
        logic mem_bus;
        logic mem_read;
        logic mem_write;
    } ctrl_t;

endpackage

// File: rtl/rs_alus_decode.sv
// ---------------------------------------------------------------------------
// rs_alus_decode
// Combinational mapping from (opcode, ALU class) to the seven ALU select
// lines.
//   ir_in     in  4  opcode from the instruction register
//   alu_class in  2  NONE / PASS / EXEC for the current control state
//   alus      out 7  ALU select, bit 6 = ALUS1 ... bit 0 = ALUS7
// ---------------------------------------------------------------------------
module rs_alus_decode
    import rs_cpu_pkg::*;
(
    input  logic [3:0]  ir_in,
    input  alu_class_t  alu_class,
    output logic [6:0]  alus
);

    always_comb begin
        alus = 7'b0000000;
        case (alu_class)
            ALU_CLASS_PASS: alus = ALUS_PASS;
            ALU_CLASS_EXEC: begin
                case (ir_in)
                    OP_ADD:  alus = ALUS_ADD;
                    OP_SUB:  alus = ALUS_SUB;
                    OP_INAC: alus = ALUS_INAC;
                    OP_CLAC: alus = ALUS_CLAC;
                    OP_AND:  alus = ALUS_AND;
                    OP_OR:   alus = ALUS_OR;
                    OP_XOR:  alus = ALUS_XOR;
                    OP_NOT:  alus = ALUS_NOT;
                    default: alus = 7'b0000000;
                endcase
            end
            default: alus = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/rs_control_unit.sv
// ---------------------------------------------------------------------------
// rs_control_unit
// Hardwired Moore control unit for the 8-bit accumulator CPU. Sequences
// fetch / decode / execute, holds the Z flag and resolves conditional jumps.
//   CLK, RESET               clock, synchronous active-high reset
//   IR_IN[3:0]               opcode (used from DECODE onward)
//   Z_FROMAC                 zero indication of the ALU result
//   Z_FLAG                   registered Z flag
//   AR/PC/DR/IR/R/AC_LOAD    register load strobes, PC_INC increment strobe
//   PC/DR/R/AC/MEM_BUS       bus drive enables
//   MEM_READ, MEM_WRITE      memory strobes
//   ALUS1..ALUS7             ALU function select
// Every output is forced to 0 while RESET is high, so a reset arriving in a
// store cycle cannot produce a write.
// ---------------------------------------------------------------------------
module rs_control_unit
    import rs_cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] IR_IN,
    input  logic       Z_FROMAC,
    output logic       Z_FLAG,
    output logic       AR_LOAD,
    output logic       PC_LOAD,
    output logic       PC_INC,
    output logic       DR_LOAD,
    output logic       IR_LOAD,
    output logic       R_LOAD,
    output logic       AC_LOAD,
    output logic       PC_BUS,
    output logic       DR_BUS,
    output logic       R_BUS,
    output logic       AC_BUS,
    output logic       MEM_BUS,
    output logic       MEM_READ,
    output logic       MEM_WRITE,
    output logic       ALUS1,
    output logic       ALUS2,
    output logic       ALUS3,
    output logic       ALUS4,
    output logic       ALUS5,
    output logic       ALUS6,
    output logic       ALUS7
);

    localparam int CTRL_W = $bits(ctrl_t);
    localparam int OUT_W  = CTRL_W + 7 + 1;

    state_t     state_reg;
    state_t     state_next;
    logic       z_flag_reg;
    logic       z_flag_next;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_out;
    alu_class_t alu_class;
    logic [6:0] alus_raw;
    logic [6:0] alus_out;
    logic [OUT_W-1:0] out_raw;
    logic [OUT_W-1:0] out_gated;

    // State and flag registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_reg  <= ST_FETCH1;
            z_flag_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            z_flag_reg <= z_flag_next;
        end
    end

    // ALU1 is reached only by the eight flag-setting ALU opcodes.
    always_comb begin
        z_flag_next = z_flag_reg;
        if (state_reg == ST_ALU1) begin
            z_flag_next = Z_FROMAC;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = ST_FETCH1;
        case (state_reg)
            ST_FETCH1: state_next = ST_FETCH2;
            ST_FETCH2: state_next = ST_FETCH3;
            ST_FETCH3: state_next = ST_DECODE;
            ST_DECODE: begin
                case (IR_IN)
                    OP_NOP:  state_next = ST_FETCH1;
                    OP_LDAC: state_next = ST_OPRD;
                    OP_STAC: state_next = ST_OPRD;
                    OP_MVAC: state_next = ST_MV1;
                    OP_MOVR: state_next = ST_MR1;
                    OP_JUMP: state_next = ST_JMP1;
                    OP_JMPZ: state_next = z_flag_reg ? ST_JMP1 : ST_SKIP;
                    OP_JPNZ: state_next = z_flag_reg ? ST_SKIP : ST_JMP1;
                    default: state_next = ST_ALU1;
                endcase
            end
            // OPRD is shared by LDAC and STAC; the opcode picks the branch.
            ST_OPRD:   state_next = (IR_IN == OP_STAC) ? ST_ST2 : ST_LD2;
            ST_LD2:    state_next = ST_LD3;
            ST_LD3:    state_next = ST_LD4;
            ST_ST2:    state_next = ST_ST3;
            ST_JMP1:   state_next = ST_JMP2;
            default:   state_next = ST_FETCH1;
        endcase
    end

    // Moore output decode
    always_comb begin
        ctrl_raw  = '0;
        alu_class = ALU_CLASS_NONE;
        case (state_reg)
            ST_FETCH1, ST_DECODE: begin
                ctrl_raw.pc_bus  = 1'b1;
                ctrl_raw.ar_load = 1'b1;
            end
            ST_FETCH2, ST_OPRD: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.mem_bus  = 1'b1;
                ctrl_raw.dr_load  = 1'b1;
                ctrl_raw.pc_inc   = 1'b1;
            end
            ST_FETCH3: begin
                ctrl_raw.dr_bus  = 1'b1;
                ctrl_raw.ir_load = 1'b1;
            end
            ST_LD2, ST_ST2: begin
                ctrl_raw.dr_bus  = 1'b1;
                ctrl_raw.ar_load = 1'b1;
            end
            // Operand read without PC increment: the PC is about to be
            // reloaded or the second read uses an address from DR.
            ST_LD3, ST_JMP1: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.mem_bus  = 1'b1;
                ctrl_raw.dr_load  = 1'b1;
            end
            ST_LD4: begin
                ctrl_raw.dr_bus  = 1'b1;
                ctrl_raw.ac_load = 1'b1;
                alu_class        = ALU_CLASS_PASS;
            end
            ST_ST3: begin
                ctrl_raw.ac_bus    = 1'b1;
                ctrl_raw.mem_write = 1'b1;
            end
            ST_MV1: begin
                ctrl_raw.ac_bus = 1'b1;
                ctrl_raw.r_load = 1'b1;
            end
            ST_MR1: begin
                ctrl_raw.r_bus   = 1'b1;
                ctrl_raw.ac_load = 1'b1;
                alu_class        = ALU_CLASS_PASS;
            end
            ST_JMP2: begin
                ctrl_raw.dr_bus  = 1'b1;
                ctrl_raw.pc_load = 1'b1;
            end
            ST_SKIP: begin
                ctrl_raw.pc_inc = 1'b1;
            end
            ST_ALU1: begin
                // INAC, CLAC and NOT work on AC alone; the rest take R.
                ctrl_raw.ac_load = 1'b1;
                ctrl_raw.r_bus   = !((IR_IN == OP_INAC) || (IR_IN == OP_CLAC) ||
                                     (IR_IN == OP_NOT));
                alu_class        = ALU_CLASS_EXEC;
            end
            default: begin
                ctrl_raw  = '0;
                alu_class = ALU_CLASS_NONE;
            end
        endcase
    end

    rs_alus_decode u_alus_decode (
        .ir_in     (IR_IN),
        .alu_class (alu_class),
        .alus      (alus_raw)
    );

    // Force every output low while reset is asserted.
    assign out_raw = {ctrl_raw, alus_raw, z_flag_reg};

    generate
        for (genvar gi = 0; gi < OUT_W; gi++) begin : g_reset_gate
            assign out_gated[gi] = out_raw[gi] & ~RESET;
        end
    endgenerate

    assign ctrl_out = ctrl_t'(out_gated[OUT_W-1 -: CTRL_W]);
    assign alus_out = out_gated[7:1];
    assign Z_FLAG   = out_gated[0];

    assign AR_LOAD   = ctrl_out.ar_load;
    assign PC_LOAD   = ctrl_out.pc_load;
    assign PC_INC    = ctrl_out.pc_inc;
    assign DR_LOAD   = ctrl_out.dr_load;
    assign IR_LOAD   = ctrl_out.ir_load;
    assign R_LOAD    = ctrl_out.r_load;
    assign AC_LOAD   = ctrl_out.ac_load;
    assign PC_BUS    = ctrl_out.pc_bus;
    assign DR_BUS    = ctrl_out.dr_bus;
    assign R_BUS     = ctrl_out.r_bus;
    assign AC_BUS    = ctrl_out.ac_bus;
    assign MEM_BUS   = ctrl_out.mem_bus;
    assign MEM_READ  = ctrl_out.mem_read;
    assign MEM_WRITE = ctrl_out.mem_write;

    assign ALUS1 = alus_out[6];
    assign ALUS2 = alus_out[5];
    assign ALUS3 = alus_out[4];
    assign ALUS4 = alus_out[3];
    assign ALUS5 = alus_out[2];
    assign ALUS6 = alus_out[1];
    assign ALUS7 = alus_out[0];

endmodule

// File: tb/tb_rs_control_unit.sv
// ---------------------------------------------------------------------------
// tb_rs_control_unit
// Drives opcodes one instruction at a time and scores each instruction
// against a per-instruction summary (cycle count, strobe counts and where
// they fall, ALU select at the AC load, Z flag after) derived from the
// instruction-level behaviour of the CPU.
// ---------------------------------------------------------------------------
module tb_rs_control_unit;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] IR_IN;
    logic       Z_FROMAC;
    logic       Z_FLAG;
    logic       AR_LOAD, PC_LOAD, PC_INC, DR_LOAD, IR_LOAD, R_LOAD, AC_LOAD;
    logic       PC_BUS, DR_BUS, R_BUS, AC_BUS, MEM_BUS;
    logic       MEM_READ, MEM_WRITE;
    logic       ALUS1, ALUS2, ALUS3, ALUS4, ALUS5, ALUS6, ALUS7;

    rs_control_unit dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .IR_IN     (IR_IN),
        .Z_FROMAC  (Z_FROMAC),
        .Z_FLAG    (Z_FLAG),
        .AR_LOAD   (AR_LOAD),
        .PC_LOAD   (PC_LOAD),
        .PC_INC    (PC_INC),
        .DR_LOAD   (DR_LOAD),
        .IR_LOAD   (IR_LOAD),
        .R_LOAD    (R_LOAD),
        .AC_LOAD   (AC_LOAD),
        .PC_BUS    (PC_BUS),
        .DR_BUS    (DR_BUS),
        .R_BUS     (R_BUS),
        .AC_BUS    (AC_BUS),
        .MEM_BUS   (MEM_BUS),
        .MEM_READ  (MEM_READ),
        .MEM_WRITE (MEM_WRITE),
        .ALUS1     (ALUS1),
        .ALUS2     (ALUS2),
        .ALUS3     (ALUS3),
        .ALUS4     (ALUS4),
        .ALUS5     (ALUS5),
        .ALUS6     (ALUS6),
        .ALUS7     (ALUS7)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit z_model  = 1'b0;

    // Strobe vector order:
    // AR_LOAD PC_LOAD PC_INC DR_LOAD IR_LOAD R_LOAD AC_LOAD
    // PC_BUS DR_BUS R_BUS AC_BUS MEM_BUS MEM_READ MEM_WRITE
    localparam logic [13:0] VEC_FETCH1 = 14'b1000000_1000000;
    localparam logic [13:0] VEC_LD3    = 14'b0001000_0000110;

    function automatic logic [13:0] ctrl_vec();
        return {AR_LOAD, PC_LOAD, PC_INC, DR_LOAD, IR_LOAD, R_LOAD, AC_LOAD,
                PC_BUS, DR_BUS, R_BUS, AC_BUS, MEM_BUS, MEM_READ, MEM_WRITE};
    endfunction

    function automatic logic [6:0] alus_vec();
        return {ALUS1, ALUS2, ALUS3, ALUS4, ALUS5, ALUS6, ALUS7};
    endfunction

    task automatic check_val(input string tag, input int unsigned got,
                             input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // ALU select the accumulator must see when it loads, by opcode.
    function automatic logic [6:0] exp_alus(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 7'b0100000;
            4'h8: return 7'b1100000;
            4'h9: return 7'b1011000;
            4'hA: return 7'b1001000;
            4'hB: return 7'b0000000;
            4'hC: return 7'b0000001;
            4'hD: return 7'b0000011;
            4'hE: return 7'b0000101;
            4'hF: return 7'b0000111;
            default: return 7'b0000000;
        endcase
    endfunction

    // Runs one instruction starting at a negedge where the DUT is in FETCH1.
    // zmode: 0/1 hold Z_FROMAC at that value, 2 randomise it every cycle.
    task automatic run_instr(input logic [3:0] op, input int zmode);
        int   cyc_done;
        bit   done, taken, uses_ac, is_alu;
        int   n_inc, n_pcl, n_rd, n_wr, n_acl, n_rl, viol, stray;
        int   acl_idx, wr_idx, pcl_idx;
        logic [6:0]  alus_at;
        logic [13:0] cv;
        bit   z_after;
        int   exp_cyc, exp_inc, exp_rd;
        string tg;

        done = 0; cyc_done = 0;
        n_inc = 0; n_pcl = 0; n_rd = 0; n_wr = 0; n_acl = 0; n_rl = 0;
        viol = 0; stray = 0; acl_idx = -1; wr_idx = -1; pcl_idx = -1;
        alus_at = 7'h0;
        is_alu  = (op >= 4'h8);
        uses_ac = is_alu || (op == 4'h1) || (op == 4'h4);
        taken   = (op == 4'h5) || (op == 4'h6 && z_model) || (op == 4'h7 && !z_model);
        z_after = z_model;
        tg      = $sformatf("op%0h", op);
        IR_IN   = op;

        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            cv = ctrl_vec();
            if (cyc >= 4 && PC_BUS && AR_LOAD) begin
                done = 1; cyc_done = cyc;
                break;
            end
            if (cyc == 0) begin
                check_val({tg, "_fetch1"}, cv, VEC_FETCH1);
                check_val({tg, "_zflag"}, Z_FLAG, z_model);
            end
            if ($countones({PC_BUS, DR_BUS, R_BUS, AC_BUS, MEM_BUS}) > 1) viol++;
            if (MEM_READ && MEM_WRITE) viol++;
            if (PC_INC) n_inc++;
            if (MEM_READ) n_rd++;
            if (R_LOAD) n_rl++;
            if (MEM_WRITE) begin n_wr++; wr_idx = cyc; end
            if (PC_LOAD) begin n_pcl++; pcl_idx = cyc; end
            if (AC_LOAD) begin
                n_acl++; acl_idx = cyc; alus_at = alus_vec();
            end else if (alus_vec() != 7'h0) begin
                stray++;
            end
            if (zmode == 2) Z_FROMAC = 1'($urandom_range(0, 1));
            else            Z_FROMAC = 1'(zmode);
            // Value present at the edge that ends the ALU execute cycle.
            if (AC_LOAD && is_alu) z_after = Z_FROMAC;
            @(negedge CLK);
        end

        if (!done) begin
            check_val({tg, "_timeout"}, 0, 1);
            $fatal(1, "instruction did not return to FETCH1");
        end

        case (op)
            4'h0: exp_cyc = 4;
            4'h1: exp_cyc = 8;
            4'h2: exp_cyc = 7;
            4'h5: exp_cyc = 6;
            4'h6, 4'h7: exp_cyc = taken ? 6 : 5;
            default: exp_cyc = 5;
        endcase
        exp_inc = 1 + ((op == 4'h1 || op == 4'h2) ? 1 : 0)
                    + ((op == 4'h6 || op == 4'h7) && !taken ? 1 : 0);
        exp_rd  = 1 + (op == 4'h1 ? 2 : 0) + (op == 4'h2 ? 1 : 0) + (taken ? 1 : 0);

        check_val({tg, "_cycles"},   cyc_done, exp_cyc);
        check_val({tg, "_excl"},     viol, 0);
        check_val({tg, "_pc_inc"},   n_inc, exp_inc);
        check_val({tg, "_mem_read"}, n_rd, exp_rd);
        check_val({tg, "_mem_wr"},   n_wr, (op == 4'h2) ? 1 : 0);
        check_val({tg, "_pc_load"},  n_pcl, taken ? 1 : 0);
        check_val({tg, "_r_load"},   n_rl, (op == 4'h3) ? 1 : 0);
        check_val({tg, "_ac_load"},  n_acl, uses_ac ? 1 : 0);
        check_val({tg, "_alus_stray"}, stray, 0);
        if (uses_ac) begin
            check_val({tg, "_ac_idx"}, acl_idx, exp_cyc - 1);
            check_val({tg, "_alus"},   alus_at, exp_alus(op));
        end
        if (op == 4'h2) check_val({tg, "_wr_idx"}, wr_idx, exp_cyc - 1);
        if (taken)      check_val({tg, "_pcl_idx"}, pcl_idx, exp_cyc - 1);

        z_model = z_after;
        $display("instr op=%0h z_in=%0b cycles=%0d z_out=%0b", op,
                 (op == 4'h6 || op == 4'h7) ? taken ^ (op == 4'h7) : z_model,
                 cyc_done, z_model);
    endtask

    // LDAC interrupted by a 2-cycle reset while in LD3.
    task automatic reset_mid_ld3();
        IR_IN = 4'h1;
        Z_FROMAC = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge CLK);
        #1;
        check_val("ld3_reached", ctrl_vec(), VEC_LD3);
        RESET = 1'b1;
        #1;
        check_val("rst_ctrl0", ctrl_vec(), 0);
        check_val("rst_alus0", alus_vec(), 0);
        check_val("rst_z0", Z_FLAG, 0);
        @(negedge CLK);
        #1;
        check_val("rst_ctrl1", ctrl_vec(), 0);
        check_val("rst_z1", Z_FLAG, 0);
        @(negedge CLK);
        RESET = 1'b0;
        z_model = 1'b0;
        $display("reset applied for 2 cycles during LD3");
    endtask

    initial begin
        RESET    = 1'b1;
        IR_IN    = 4'h0;
        Z_FROMAC = 1'b0;
        @(negedge CLK);
        #1;
        check_val("reset_ctrl", ctrl_vec(), 0);
        check_val("reset_alus", alus_vec(), 0);
        @(negedge CLK);
        RESET = 1'b0;

        // Directed sequence
        run_instr(4'h9, 1);  // SUB sets Z
        run_instr(4'h1, 1);  // LDAC leaves Z alone
        run_instr(4'h6, 0);  // JMPZ taken
        run_instr(4'h7, 0);  // JPNZ not taken
        run_instr(4'h2, 0);  // STAC
        run_instr(4'h0, 1);  // NOP
        run_instr(4'h3, 1);  // MVAC
        run_instr(4'h4, 1);  // MOVR
        run_instr(4'hB, 0);  // CLAC clears Z
        run_instr(4'h6, 1);  // JMPZ not taken
        run_instr(4'h7, 1);  // JPNZ taken
        run_instr(4'h5, 1);  // JUMP
        run_instr(4'hA, 1);  // INAC sets Z again
        reset_mid_ld3();
        run_instr(4'h8, 0);  // first instruction after reset

        // Random opcode stream
        for (int k = 0; k < 500; k++) begin
            run_instr(4'($urandom_range(0, 15)), 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
